// File: rtl/pong_game_ctrl_pkg.sv
// Shared encodings for the pong match-flow controller and its HUD consumers.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        WIN_NONE  = 2'b00,
        WIN_LEFT  = 2'b01,
        WIN_RIGHT = 2'b10,
        WIN_TIE   = 2'b11
    } winner_e;

    localparam int         WIN_PTS_DEF = 3;
    localparam logic [1:0] CD_START    = 2'd3;

    // Frame counters must hold the larger of the two frame budgets without wrapping.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Link between the match controller and the ball block: start level out, score/guiwei back.
interface pong_game_ctrl_if;

    logic       start;
    logic [3:0] score;
    logic       guiwei;

    modport master (output start, input score, input guiwei);
    modport slave  (input start, output score, output guiwei);

endinterface

// File: rtl/pong_game_ctrl_frame_btn_edge.sv
// Pushbutton conditioner: 2-flop synchronizer, frame-rate sampler, one-cycle rising-edge press.
module frame_btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic frame_tick,
    input  logic btn_in,
    output logic press
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic btn_q, btn_d;

    always_comb begin
        sync1_d = btn_in;
        sync2_d = sync1_q;
        btn_d   = btn_q;
        // Sampling only at frame rate debounces contact chatter shorter than a frame.
        if (frame_tick) begin
            btn_d = sync2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            btn_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            btn_q   <= btn_d;
        end
    end

    assign press = frame_tick & sync2_q & ~btn_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Match-flow controller: idle, serve countdown, rally play, game over; drives ball start and HUD status.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int DIGIT_FRAMES = 60,
    parameter int FLASH_FRAMES = 30,
    parameter int WIN_PTS      = WIN_PTS_DEF
) (
    input  logic                    vga_clk,
    input  logic                    sys_rst,
    input  logic                    frame_tick,
    input  logic                    start_btn,
    pong_game_ctrl_if.master        ball,
    output logic [1:0]              state,
    output logic [1:0]              countdown,
    output logic [1:0]              winner,
    output logic                    point_flash
);

    localparam int                 CNT_W      = cnt_width(DIGIT_FRAMES, FLASH_FRAMES);
    localparam logic [CNT_W-1:0]   DIGIT_LAST = CNT_W'(DIGIT_FRAMES - 1);
    localparam logic [CNT_W-1:0]   FLASH_LOAD = CNT_W'(FLASH_FRAMES);
    localparam logic [1:0]         WIN_V      = 2'(WIN_PTS);

    state_e             state_q, state_d;
    winner_e            winner_q, winner_d;
    logic               start_q, start_d;
    logic [1:0]         cd_q, cd_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]   flash_cnt_q, flash_cnt_d;

    logic press;
    logic right_won;
    logic left_won;
    logic flash_reload;

    frame_btn_edge u_start_btn (
        .clk        (vga_clk),
        .rst        (sys_rst),
        .frame_tick (frame_tick),
        .btn_in     (start_btn),
        .press      (press)
    );

    always_comb begin
        state_d      = state_q;
        winner_d     = winner_q;
        cd_d         = cd_q;
        frame_cnt_d  = frame_cnt_q;
        flash_reload = 1'b0;
        right_won    = (ball.score[1:0] == WIN_V);
        left_won     = (ball.score[3:2] == WIN_V);

        unique case (state_q)
            ST_IDLE: begin
                if (press) begin
                    state_d     = ST_SERVE;
                    cd_d        = CD_START;
                    frame_cnt_d = '0;
                end
            end
            ST_SERVE: begin
                if (frame_tick) begin
                    if (frame_cnt_q == DIGIT_LAST) begin
                        frame_cnt_d = '0;
                        if (cd_q == 2'd1) begin
                            state_d = ST_PLAY;
                            cd_d    = 2'd0;
                        end else begin
                            cd_d = cd_q - 2'd1;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                if (ball.guiwei) begin
                    flash_reload = 1'b1;
                    if (right_won || left_won) begin
                        state_d  = ST_OVER;
                        winner_d = winner_e'({right_won, left_won});
                    end
                end
            end
            ST_OVER: begin
                if (press) begin
                    state_d  = ST_IDLE;
                    winner_d = WIN_NONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // OVER keeps start high so the ball block still shows the final score.
        start_d = (state_d == ST_PLAY) || (state_d == ST_OVER);

        if (flash_reload) begin
            flash_cnt_d = FLASH_LOAD;
        end else if ((state_d == ST_IDLE) && (state_q != ST_IDLE)) begin
            flash_cnt_d = '0;
        end else if (frame_tick && (flash_cnt_q != '0)) begin
            flash_cnt_d = flash_cnt_q - 1'b1;
        end else begin
            flash_cnt_d = flash_cnt_q;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            winner_q    <= WIN_NONE;
            start_q     <= 1'b0;
            cd_q        <= 2'd0;
            frame_cnt_q <= '0;
            flash_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            start_q     <= start_d;
            cd_q        <= cd_d;
            frame_cnt_q <= frame_cnt_d;
            flash_cnt_q <= flash_cnt_d;
        end
    end

    assign ball.start  = start_q;
    assign state       = state_q;
    assign countdown   = cd_q;
    assign winner      = winner_q;
    assign point_flash = (flash_cnt_q != '0);

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: stimulus pushes predicted outputs, a monitor pops and compares every cycle.
module tb_pong_game_ctrl;

    localparam int D  = 4;
    localparam int F  = 5;
    localparam int WP = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       ft;
    logic       btn;
    logic [1:0] state;
    logic [1:0] countdown;
    logic [1:0] winner;
    logic       point_flash;

    pong_game_ctrl_if bif ();

    pong_game_ctrl #(
        .DIGIT_FRAMES (D),
        .FLASH_FRAMES (F),
        .WIN_PTS      (WP)
    ) dut (
        .vga_clk     (clk),
        .sys_rst     (rst),
        .frame_tick  (ft),
        .start_btn   (btn),
        .ball        (bif),
        .state       (state),
        .countdown   (countdown),
        .winner      (winner),
        .point_flash (point_flash)
    );

    typedef struct packed {
        logic [1:0] st;
        logic       start;
        logic [1:0] cd;
        logic [1:0] win;
        logic       flash;
    } obs_t;

    obs_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: match phase, ticks elapsed in serve, frames since last point.
    int         m_state;
    int         m_serve_ticks;
    int         m_flash_age;
    bit         m_flash_on;
    logic [1:0] m_win;
    bit         m_hist[$];
    bit         m_last_lvl;

    function automatic obs_t model_obs();
        obs_t o;
        o.st    = 2'(m_state);
        o.start = (m_state == 2) || (m_state == 3);
        o.cd    = (m_state == 1) ? 2'(3 - m_serve_ticks / D) : 2'd0;
        o.win   = m_win;
        o.flash = m_flash_on;
        return o;
    endfunction

    task automatic model_reset();
        m_state       = 0;
        m_serve_ticks = 0;
        m_flash_age   = 0;
        m_flash_on    = 0;
        m_win         = 2'b00;
        m_last_lvl    = 0;
        m_hist.delete();
        m_hist.push_back(1'b0);
        m_hist.push_back(1'b0);
    endtask

    task automatic model_step(input bit r, input bit t, input bit b, input bit g, input logic [3:0] s);
        bit lvl;
        bit pr;
        bit reload;
        if (r) begin
            model_reset();
        end else begin
            lvl    = m_hist[0];
            pr     = t && lvl && !m_last_lvl;
            reload = 0;
            if (t) m_last_lvl = lvl;
            void'(m_hist.pop_front());
            m_hist.push_back(b);
            case (m_state)
                0: if (pr) begin
                    m_state       = 1;
                    m_serve_ticks = 0;
                end
                1: if (t) begin
                    m_serve_ticks++;
                    if (m_serve_ticks == 3 * D) m_state = 2;
                end
                2: if (g) begin
                    reload      = 1;
                    m_flash_on  = 1;
                    m_flash_age = 0;
                    if ((s[1:0] == WP) || (s[3:2] == WP)) begin
                        m_state = 3;
                        m_win   = {s[1:0] == WP, s[3:2] == WP};
                    end
                end
                default: if (pr) begin
                    m_state    = 0;
                    m_win      = 2'b00;
                    m_flash_on = 0;
                end
            endcase
            if (!reload && t && m_flash_on) begin
                m_flash_age++;
                if (m_flash_age >= F) m_flash_on = 0;
            end
        end
    endtask

    task automatic drive(input bit r, input bit t, input bit b, input bit g, input logic [3:0] s);
        @(negedge clk);
        rst        = r;
        ft         = t;
        btn        = b;
        bif.guiwei = g;
        bif.score  = s;
        model_step(r, t, b, g, s);
        exp_q.push_back(model_obs());
    endtask

    task automatic frames(input int n, input bit b);
        for (int i = 0; i < n; i++) begin
            drive(0, 1, b, 0, 4'h0);
            drive(0, 0, b, 0, 4'h0);
            drive(0, 0, b, 0, 4'h0);
        end
    endtask

    task automatic point(input logic [3:0] s);
        drive(0, 0, 0, 1, s);
    endtask

    task automatic press_release();
        frames(3, 1);
        frames(3, 0);
    endtask

    task automatic wait_model_state(input int target, input int max_frames, input string tag);
        int n;
        n = 0;
        while (m_state != target && n < max_frames) begin
            frames(1, 0);
            n++;
        end
        if (m_state != target) begin
            vectors++;
            miscompares++;
            $display("FAIL %s timeout: model state %0d, required %0d", tag, m_state, target);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            obs_t e;
            obs_t a;
            e = exp_q.pop_front();
            a = {state, bif.start, countdown, winner, point_flash};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL outputs t=%0t got st=%0d start=%b cd=%0d win=%b flash=%b required st=%0d start=%b cd=%0d win=%b flash=%b",
                         $time, a.st, a.start, a.cd, a.win, a.flash, e.st, e.start, e.cd, e.win, e.flash);
            end
        end
    end

    initial begin
        bit         b_lvl;
        bit         r_r, t_r, g_r;
        logic [3:0] s_r;
        int         n;

        rst        = 1'b1;
        ft         = 1'b0;
        btn        = 1'b0;
        bif.guiwei = 1'b0;
        bif.score  = 4'h0;
        model_reset();

        repeat (3) drive(1, 0, 0, 0, 4'h0);
        frames(10, 0);

        // Button held for five frames: a single press, then the full countdown into play.
        frames(5, 1);
        wait_model_state(2, 40, "serve_to_play");
        frames(2, 0);

        point(4'b0001);
        frames(2, 0);
        point(4'b0001);
        frames(7, 0);

        point(4'b0111);
        frames(2, 0);
        point(4'b0001);
        frames(2, 0);

        press_release();
        press_release();

        n = 0;
        while (model_obs().cd != 2'd2 && n < 40) begin
            frames(1, 0);
            n++;
        end
        if (model_obs().cd != 2'd2) begin
            vectors++;
            miscompares++;
            $display("FAIL serve_cd2 timeout: model countdown %0d, required 2", model_obs().cd);
        end
        drive(1, 0, 0, 0, 4'h0);
        frames(2, 0);
        point(4'b1100);
        frames(7, 0);

        b_lvl = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) b_lvl = ~b_lvl;
            r_r = ($urandom_range(0, 799) == 0);
            t_r = ($urandom_range(0, 2) == 0);
            g_r = ($urandom_range(0, 14) == 0);
            s_r = 4'($urandom_range(0, 15));
            drive(r_r, t_r, b_lvl, g_r, s_r);
        end

        drive(0, 0, 0, 0, 4'h0);
        repeat (3) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
